transfer_sequencer: RTL
=======================

TRANSFER_SEQUENCER -- requirements
Module: transfer_sequencer

Interface
REQ-001 The block SHALL have parameter W_ADDR, default 16, giving the address and stride width.
REQ-002 The block SHALL have parameter W_LEN, default 10, giving the beat-count width.
REQ-003 clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 rst  input  1  Reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  Command offered.
REQ-006 cmd_ready  output  1  Command accepted when high with cmd_valid.
REQ-007 cmd_write  input  1  Transfer direction; copied to beat_write.
REQ-008 cmd_addr  input  W_ADDR  First beat address.
REQ-009 cmd_len  input  W_LEN  Beat count; 0 is illegal.
REQ-010 cmd_stride  input  W_ADDR  Address step per beat.
REQ-011 cmd_decr  input  1  1 means subtract stride, 0 means add stride.
REQ-012 abort  input  1  Terminate the active transfer.
REQ-013 beat_valid  output  1  Beat offered downstream.
REQ-014 beat_ready  input  1  Downstream accepts the beat.
REQ-015 beat_addr  output  W_ADDR  Current beat address.
REQ-016 beat_write  output  1  Latched cmd_write.
REQ-017 beat_last  output  1  Current beat is the final beat.
REQ-018 beat_idx  output  W_LEN  Zero-based index of the current beat.
REQ-019 busy  output  1  High when the state is not IDLE.
REQ-020 done  output  1  One-cycle pulse on normal completion.
REQ-021 aborted  output  1  One-cycle pulse on abort.
REQ-022 err  output  1  One-cycle pulse on a zero-length command.

Function
REQ-023 The state machine SHALL have three states: IDLE, RUN and FIN.
REQ-024 cmd_ready SHALL equal (state==IDLE) and not rst; commands are only accepted while cmd_ready is high.
REQ-025 In IDLE, on cmd_valid&cmd_ready, the block SHALL latch all cmd_* fields, clear beat_idx to 0 and load cmd_addr as the current address.
- If cmd_len==0, the block SHALL stay in IDLE and pulse err in the following cycle, with no beats issued.
- Otherwise, the block SHALL enter RUN.
REQ-026 In RUN, beat_valid SHALL be 1.
- beat_addr, beat_idx, beat_write and beat_last SHALL hold stable while beat_valid&!beat_ready.
- beat_valid SHALL NOT drop without a handshake or an abort.
REQ-027 Latency: with a command accepted at edge N, beat_valid SHALL first be high in the cycle after edge N, with beat_idx=0 and beat_addr=cmd_addr.
REQ-028 beat_last SHALL equal (beat_idx==len-1) during RUN and 0 in all other states.
REQ-029 On a handshake (beat_valid&beat_ready) that is not the last beat, the block SHALL apply the following at the next edge:
- beat_idx increments by 1.
- The address becomes addr+stride, or addr-stride when cmd_decr=1, computed modulo 2^W_ADDR; wrap-around is silent.
REQ-030 A back-to-back handshake every cycle SHALL sustain one beat per clock.
REQ-031 On the last-beat handshake, the block SHALL enter FIN.
REQ-032 In FIN, done SHALL be 1 and busy 1 for exactly one cycle, after which the block SHALL return to IDLE.
REQ-033 When abort is high in RUN, the block SHALL go to IDLE at the next edge and pulse aborted for one cycle, with no done.
REQ-034 abort SHALL take priority over a simultaneous handshake, including on the last beat.
REQ-035 abort SHALL be ignored in IDLE and FIN.
REQ-036 beat_valid SHALL be 0 in IDLE and FIN.
REQ-037 done, aborted and err SHALL be mutually exclusive and never assert in the same cycle.

Reset
REQ-038 While rst is asserted, the block SHALL force the following asynchronously, regardless of clk:
- state=IDLE;
- beat_idx=0 and beat_addr=0;
- beat_valid, beat_last, beat_write, busy, done, aborted, err and cmd_ready all 0.
REQ-039 rst asserted mid-RUN SHALL discard the transfer without any done or aborted pulse.
REQ-040 The first command SHALL be accepted no earlier than the first rising edge after rst deasserts.

Verification
REQ-041 Scenario: addr=0x0100, len=4, stride=4, incr, beat_ready=1 constantly -> beats at 0x0100/0x0104/0x0108/0x010C on consecutive cycles; beat_last on the 4th beat; done one cycle later; cmd_ready high again the cycle after done.
REQ-042 Scenario: addr=0x0002, len=3, stride=4, decr -> beat addresses 0x0002/0xFFFE/0xFFFA, with wrap and no error.
REQ-043 Scenario: len=2, beat_ready low for 3 cycles on beat 0 -> beat_valid held high and beat_addr/beat_idx stable for those 3 cycles; transfer completes after beat_ready rises.
REQ-044 Scenario: len=5, abort asserted together with the handshake of beat 2 -> aborted pulses once, no done, no beat 3, and the block is in IDLE.
REQ-045 Scenario: cmd_len=0 -> err pulses one cycle after acceptance; beat_valid never rises; busy stays 0.
REQ-046 Scenario: rst pulsed mid-RUN at beat 1 of 4 -> all outputs go to 0 immediately, no done or aborted; a new command is accepted after rst falls.

Source files
------------

// File: rtl/transfer_sequencer.sv
// Multi-beat address sequencer: expands one command
// into len strided beats with valid/ready, abort and error pulses.
module transfer_sequencer #(
  parameter int W_ADDR = 16,
  parameter int W_LEN  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [W_ADDR-1:0] cmd_addr,
  input  logic [W_LEN-1:0]  cmd_len,
  input  logic [W_ADDR-1:0] cmd_stride,
  input  logic              cmd_decr,
  input  logic              abort,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [W_ADDR-1:0] beat_addr,
  output logic              beat_write,
  output logic              beat_last,
  output logic [W_LEN-1:0]  beat_idx,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [W_LEN-1:0] ONE = 1;

  state_t state, state_nx;

  logic [W_ADDR-1:0] addr_q;
  logic [W_ADDR-1:0] stride_q;
  logic [W_LEN-1:0]  idx_q;
  logic [W_LEN-1:0]  len_q;
  logic              decr_q;
  logic              write_q;
  logic              err_q;
  logic              abt_q;

  logic accept;
  logic hs;
  logic last;

  assign accept = cmd_valid && cmd_ready;
  assign hs     = beat_valid && beat_ready;
  assign last   = (idx_q == (len_q - ONE));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state: abort beats the handshake, FIN lasts one cycle
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && (cmd_len != '0)) state_nx = RUN;
      RUN: begin
        if (abort)           state_nx = IDLE;
        else if (hs && last) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    cmd_ready  = 1'b0;
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: cmd_ready = !rst;
      RUN: begin
        beat_valid = 1'b1;
        beat_last  = last;
        busy       = 1'b1;
      end
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // command latch, beat advance and one-shot pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      decr_q   <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      abt_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      abt_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= cmd_addr;
            stride_q <= cmd_stride;
            len_q    <= cmd_len;
            decr_q   <= cmd_decr;
            write_q  <= cmd_write;
            idx_q    <= '0;
            err_q    <= (cmd_len == '0);
          end
        end
        RUN: begin
          if (abort) begin
            abt_q <= 1'b1;
          end else if (hs && !last) begin
            idx_q  <= idx_q + ONE;
            addr_q <= decr_q ? addr_q - stride_q
                             : addr_q + stride_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign beat_addr  = addr_q;
  assign beat_idx   = idx_q;
  assign beat_write = write_q;
  assign aborted    = abt_q;
  assign err        = err_q;

endmodule
